// File: rtl/vga_pkg.sv
// Shared VGA geometry, field widths and the plot-arbiter state encoding.
// Reused by the sprite controllers so everyone agrees on screen size.
package vga_pkg;

  localparam int XMAX  = 160;
  localparam int YMAX  = 120;
  localparam int X_W   = 8;
  localparam int Y_W   = 7;
  localparam int CLR_W = 3;

  typedef enum logic {
    CLEAR = 1'b0,
    SERVE = 1'b1
  } state_t;

  // True when the pixel lies on the visible 160x120 screen.
  function automatic logic in_range(input logic [X_W-1:0] px, input logic [Y_W-1:0] py);
    return (px < X_W'(XMAX)) && (py < Y_W'(YMAX));
  endfunction

endpackage

// File: rtl/vga_plot_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered pointer.
// The pointer names the requester that wins when both ask at once.
module rr_arb2 (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic ptr;

  // Grant the lone requester, or the pointed-to one when both request.
  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (req[0] && (!req[1] || !ptr)) begin
        grant = 2'b01;
      end else if (req[1]) begin
        grant = 2'b10;
      end
    end
  end

  // After serving requester n, favour the other one next time.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ptr <= 1'b0;
    end else if (grant[0]) begin
      ptr <= 1'b1;
    end else if (grant[1]) begin
      ptr <= 1'b0;
    end
  end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Shares the VGA adapter pixel-write port between two requesters and owns
// a full-screen clear sweep that runs after reset and on clear_req.
module vga_plot_arbiter
  import vga_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             r0_valid,
  input  logic [X_W-1:0]   r0_x,
  input  logic [Y_W-1:0]   r0_y,
  input  logic [CLR_W-1:0] r0_colour,
  output logic             r0_ready,
  input  logic             r1_valid,
  input  logic [X_W-1:0]   r1_x,
  input  logic [Y_W-1:0]   r1_y,
  input  logic [CLR_W-1:0] r1_colour,
  output logic             r1_ready,
  input  logic             clear_req,
  input  logic [CLR_W-1:0] clear_colour,
  output logic             clear_busy,
  output logic [X_W-1:0]   x,
  output logic [Y_W-1:0]   y,
  output logic [CLR_W-1:0] colour,
  output logic             plot
);

  state_t           state;
  logic [X_W-1:0]   cx;
  logic [Y_W-1:0]   cy;
  logic [CLR_W-1:0] fill;
  logic [1:0]       grant;
  logic             serve_en;

  // Pending clear takes priority, so requesters are only served when none is asked.
  assign serve_en = (state == SERVE) && !clear_req;

  rr_arb2 u_arb (
    .clk    (clk),
    .resetn (resetn),
    .enable (serve_en),
    .req    ({r1_valid, r0_valid}),
    .grant  (grant)
  );

  assign r0_ready = grant[0];
  assign r1_ready = grant[1];

  // Sweep / serve state machine driving the registered adapter outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= CLEAR;
      cx         <= '0;
      cy         <= '0;
      fill       <= '0;
      x          <= '0;
      y          <= '0;
      colour     <= '0;
      plot       <= 1'b0;
      clear_busy <= 1'b0;
    end else begin
      // Busy tracks the cycles in which a cleared pixel is on the outputs.
      clear_busy <= (state == CLEAR);
      case (state)
        CLEAR: begin
          x      <= cx;
          y      <= cy;
          colour <= fill;
          plot   <= 1'b1;
          if (cx == X_W'(XMAX - 1)) begin
            cx <= '0;
            if (cy == Y_W'(YMAX - 1)) begin
              cy    <= '0;
              state <= SERVE;
            end else begin
              cy <= cy + 1'b1;
            end
          end else begin
            cx <= cx + 1'b1;
          end
        end
        SERVE: begin
          if (clear_req) begin
            fill  <= clear_colour;
            cx    <= '0;
            cy    <= '0;
            plot  <= 1'b0;
            state <= CLEAR;
          end else if (grant[0]) begin
            x      <= r0_x;
            y      <= r0_y;
            colour <= r0_colour;
            plot   <= in_range(r0_x, r0_y);
          end else if (grant[1]) begin
            x      <= r1_x;
            y      <= r1_y;
            colour <= r1_colour;
            plot   <= in_range(r1_x, r1_y);
          end else begin
            plot <= 1'b0;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Scoreboard bench for vga_plot_arbiter: the stimulus process predicts
// grants and pushes expected plotted pixels; a negedge monitor pops them.
module tb_vga_plot_arbiter;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       r0_valid = 1'b0, r1_valid = 1'b0;
  logic [7:0] r0_x = '0, r1_x = '0;
  logic [6:0] r0_y = '0, r1_y = '0;
  logic [2:0] r0_colour = '0, r1_colour = '0;
  logic       r0_ready, r1_ready;
  logic       clear_req = 1'b0;
  logic [2:0] clear_colour = '0;
  logic       clear_busy;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;

  vga_plot_arbiter dut (
    .clk(clk), .resetn(resetn),
    .r0_valid(r0_valid), .r0_x(r0_x), .r0_y(r0_y), .r0_colour(r0_colour), .r0_ready(r0_ready),
    .r1_valid(r1_valid), .r1_x(r1_x), .r1_y(r1_y), .r1_colour(r1_colour), .r1_ready(r1_ready),
    .clear_req(clear_req), .clear_colour(clear_colour), .clear_busy(clear_busy),
    .x(x), .y(y), .colour(colour), .plot(plot)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int c;
    int at;
    bit clr;
    bit last;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  // Reference model state
  int   clear_left = 0;
  int   ptr = 0;
  bit   g0 = 0, g1 = 0;

  bit   check_idle = 0;
  bit   check_busy_low = 0;

  always @(posedge clk) cyc++;

  // Monitor: compare every plotted pixel with the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (check_idle) begin
      tests++;
      if (plot !== 1'b0 || x !== 8'd0 || y !== 7'd0 || colour !== 3'd0 || clear_busy !== 1'b0) begin
        fails++;
        $display("FAIL reset_state cyc=%0d: got plot=%b x=%0d y=%0d c=%0d busy=%b want all 0",
                 cyc, plot, x, y, colour, clear_busy);
      end
      check_idle = 0;
    end
    if (check_busy_low) begin
      tests++;
      if (clear_busy !== 1'b0) begin
        fails++;
        $display("FAIL busy_fall cyc=%0d: got clear_busy=%b want 0", cyc, clear_busy);
      end
      check_busy_low = 0;
    end
    if (plot === 1'b1) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_plot cyc=%0d: got (%0d,%0d,%0d) want no plot", cyc, x, y, colour);
      end else begin
        e = q.pop_front();
        if (x !== 8'(e.x) || y !== 7'(e.y) || colour !== 3'(e.c) || cyc != e.at ||
            (e.clr && clear_busy !== 1'b1)) begin
          fails++;
          $display("FAIL pixel cyc=%0d: got (%0d,%0d,%0d) busy=%b want (%0d,%0d,%0d) at cyc %0d busy=%b",
                   cyc, x, y, colour, clear_busy, e.x, e.y, e.c, e.at, e.clr);
        end
        if (e.last) check_busy_low = 1;
      end
    end
    if (resetn === 1'b0) begin
      q.delete();
      check_idle = 1;
      check_busy_low = 0;
    end
  end

  task automatic push_clear(input int c, input int base);
    exp_t e;
    for (int yy = 0; yy < 120; yy++) begin
      for (int xx = 0; xx < 160; xx++) begin
        e.x = xx; e.y = yy; e.c = c;
        e.at = base + yy * 160 + xx;
        e.clr = 1'b1;
        e.last = (xx == 159) && (yy == 119);
        q.push_back(e);
      end
    end
  endtask

  task automatic push_pixel(input int px, input int py, input int pc, input int at);
    exp_t e;
    if (px < 160 && py < 120) begin
      e.x = px; e.y = py; e.c = pc; e.at = at; e.clr = 1'b0; e.last = 1'b0;
      q.push_back(e);
    end
  endtask

  // One model cycle: predict readies, check them, record expected outputs.
  task automatic step();
    bit e0, e1;
    #1;
    e0 = 0; e1 = 0;
    if (clear_left > 0) begin
      clear_left--;
    end else if (clear_req) begin
      clear_left = 19200;
      push_clear(int'(clear_colour), cyc + 2);
    end else if (r0_valid && r1_valid) begin
      if (ptr == 0) e0 = 1; else e1 = 1;
    end else if (r0_valid) begin
      e0 = 1;
    end else if (r1_valid) begin
      e1 = 1;
    end
    tests++;
    if (r0_ready !== e0 || r1_ready !== e1) begin
      fails++;
      $display("FAIL ready cyc=%0d: got r0=%b r1=%b want r0=%b r1=%b", cyc, r0_ready, r1_ready, e0, e1);
    end
    if (e0) begin
      ptr = 1;
      push_pixel(int'(r0_x), int'(r0_y), int'(r0_colour), cyc + 1);
    end
    if (e1) begin
      ptr = 0;
      push_pixel(int'(r1_x), int'(r1_y), int'(r1_colour), cyc + 1);
    end
    g0 = e0; g1 = e1;
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    r0_valid = 0; r1_valid = 0; clear_req = 0;
    resetn = 0;
    repeat (n) @(posedge clk);
    #1;
    resetn = 1;
    clear_left = 19200;
    ptr = 0;
    g0 = 0; g1 = 0;
    push_clear(0, cyc + 1);
  endtask

  task automatic rand_r0();
    r0_x = 8'($urandom_range(0, 169)); r0_y = 7'($urandom_range(0, 127)); r0_colour = 3'($urandom_range(0, 7));
  endtask

  task automatic rand_r1();
    r1_x = 8'($urandom_range(0, 169)); r1_y = 7'($urandom_range(0, 127)); r1_colour = 3'($urandom_range(0, 7));
  endtask

  initial begin
    bit done0, done1;
    // Power-up clear at colour 0
    do_reset(3);
    repeat (19200) step();
    repeat (2) step();

    // Both requesters continuously valid: strict alternation from r0
    r0_valid = 1; r1_valid = 1; rand_r0(); rand_r1();
    repeat (12) begin
      step();
      if (g0) rand_r0();
      if (g1) rand_r1();
    end
    r0_valid = 0; r1_valid = 0;
    repeat (2) step();

    // Single r1 pixel
    r1_valid = 1; r1_x = 8'd10; r1_y = 7'd20; r1_colour = 3'd3;
    step();
    r1_valid = 0;
    repeat (2) step();

    // Off-screen r0 pixel then an ordinary one
    r0_valid = 1; r0_x = 8'd160; r0_y = 7'd5; r0_colour = 3'd7;
    step();
    r0_x = 8'd7; r0_y = 7'd8; r0_colour = 3'd2;
    step();
    r0_valid = 0;
    repeat (2) step();

    // Clear at colour 5 while both requesters wait
    r0_valid = 1; r1_valid = 1; rand_r0(); rand_r1();
    r0_x = 8'd40; r1_x = 8'd41; r0_y = 7'd50; r1_y = 7'd51;
    clear_req = 1; clear_colour = 3'd5;
    step();
    clear_req = 0; clear_colour = 3'd1;
    done0 = 0; done1 = 0;
    for (int i = 0; i < 19300 && !(done0 && done1); i++) begin
      step();
      if (g0) begin done0 = 1; r0_valid = 0; end
      if (g1) begin done1 = 1; r1_valid = 0; end
    end
    r0_valid = 0; r1_valid = 0;
    repeat (2) step();

    // Randomised traffic with hold-while-not-ready behaviour
    repeat (400) begin
      step();
      if (!r0_valid || g0) begin r0_valid = ($urandom_range(0, 3) != 0); rand_r0(); end
      if (!r1_valid || g1) begin r1_valid = ($urandom_range(0, 3) != 0); rand_r1(); end
    end
    r0_valid = 0; r1_valid = 0;
    repeat (2) step();

    // Reset in the middle of a colour-6 clear
    clear_req = 1; clear_colour = 3'd6;
    step();
    clear_req = 0;
    repeat (150) step();
    do_reset(1);
    repeat (19200) step();
    repeat (3) step();

    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pixels still expected, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
